// File: rtl/lane_gate_scheduler.sv
// lane_gate_scheduler: sequences the shared parking-lane barrier.
// Arbitrates entry/exit requests round-robin, drives the barrier motor through
// OPENING -> OPEN -> CLOSING, holds the gate while a car is under it, reverses
// on obstruction during closing and flags a lane blocked for too long.
// Runs on the 1 Hz tick, so every timer counts seconds.
module lane_gate_scheduler #(
    parameter int MOVE_TIME  = 2,   // travel time up or down, 1..255
    parameter int OPEN_TIME  = 5,   // dwell after the lane clears, 1..255
    parameter int FAULT_TIME = 10   // consecutive occupied cycles before fault, > OPEN_TIME
) (
    input  logic clk_1Hz,
    input  logic rst,
    input  logic entry_req,
    input  logic exit_req,
    input  logic full,
    input  logic empty,
    input  logic car_present,
    output logic entry_grant,
    output logic exit_grant,
    output logic served_dir,
    output logic motor_up,
    output logic motor_down,
    output logic gate_open,
    output logic busy,
    output logic lane_fault
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OPENING = 2'd1,
        OPEN    = 2'd2,
        CLOSING = 2'd3
    } state_t;

    localparam logic [7:0] MOVE_LD  = 8'(MOVE_TIME);
    localparam logic [7:0] OPEN_LD  = 8'(OPEN_TIME);
    localparam logic [7:0] FAULT_LD = 8'(FAULT_TIME);

    state_t     state;
    logic       last_served;   // 0 = entry, 1 = exit; the other side wins a tie
    logic [7:0] mv_tmr;        // remaining travel cycles in OPENING/CLOSING
    logic [7:0] open_tmr;      // remaining dwell cycles in OPEN
    logic [7:0] blk_cnt;       // consecutive occupied cycles in OPEN

    logic       e_ok;
    logic       x_ok;
    logic       pick_e;
    logic       pick_x;
    logic [7:0] blk_nxt;

    // Eligibility after occupancy masking and round-robin tie break.
    always_comb begin
        e_ok    = entry_req & ~full;
        x_ok    = exit_req & ~empty;
        pick_e  = e_ok & (~x_ok | last_served);
        pick_x  = x_ok & (~e_ok | ~last_served);
        blk_nxt = (blk_cnt == 8'hFF) ? blk_cnt : blk_cnt + 8'd1;
    end

    // Gate sequencer: state, timers and all registered outputs.
    always_ff @(posedge clk_1Hz or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            last_served <= 1'b1;
            mv_tmr      <= 8'd0;
            open_tmr    <= 8'd0;
            blk_cnt     <= 8'd0;
            entry_grant <= 1'b0;
            exit_grant  <= 1'b0;
            served_dir  <= 1'b0;
            motor_up    <= 1'b0;
            motor_down  <= 1'b0;
            gate_open   <= 1'b0;
            busy        <= 1'b0;
            lane_fault  <= 1'b0;
        end else begin
            entry_grant <= 1'b0;
            exit_grant  <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_e || pick_x) begin
                        state       <= OPENING;
                        entry_grant <= pick_e;
                        exit_grant  <= pick_x;
                        served_dir  <= pick_x;
                        last_served <= pick_x;
                        mv_tmr      <= MOVE_LD;
                        motor_up    <= 1'b1;
                        busy        <= 1'b1;
                    end
                end
                OPENING: begin
                    if (mv_tmr <= 8'd1) begin
                        state     <= OPEN;
                        mv_tmr    <= 8'd0;
                        motor_up  <= 1'b0;
                        gate_open <= 1'b1;
                        open_tmr  <= OPEN_LD;
                        blk_cnt   <= 8'd0;
                    end else begin
                        mv_tmr <= mv_tmr - 8'd1;
                    end
                end
                OPEN: begin
                    if (car_present) begin
                        // Occupied lane restarts the dwell and feeds the blocked counter.
                        open_tmr <= OPEN_LD;
                        blk_cnt  <= blk_nxt;
                        if (blk_nxt >= FAULT_LD)
                            lane_fault <= 1'b1;
                    end else begin
                        blk_cnt    <= 8'd0;
                        lane_fault <= 1'b0;
                        if (open_tmr <= 8'd1) begin
                            state      <= CLOSING;
                            open_tmr   <= 8'd0;
                            gate_open  <= 1'b0;
                            motor_down <= 1'b1;
                            mv_tmr     <= MOVE_LD;
                        end else begin
                            open_tmr <= open_tmr - 8'd1;
                        end
                    end
                end
                CLOSING: begin
                    if (car_present) begin
                        // Obstruction: reverse to a full raise, same service.
                        state      <= OPENING;
                        motor_down <= 1'b0;
                        motor_up   <= 1'b1;
                        mv_tmr     <= MOVE_LD;
                    end else if (mv_tmr <= 8'd1) begin
                        state      <= IDLE;
                        mv_tmr     <= 8'd0;
                        motor_down <= 1'b0;
                        busy       <= 1'b0;
                    end else begin
                        mv_tmr <= mv_tmr - 8'd1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    motor_up   <= 1'b0;
                    motor_down <= 1'b0;
                    gate_open  <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lane_gate_scheduler.sv
// Directed vector bench for lane_gate_scheduler with default parameters.
// Output vector order: {entry_grant, exit_grant, served_dir, motor_up,
//                       motor_down, gate_open, busy, lane_fault}
// Input vector order:  {rst, entry_req, exit_req, full, empty, car_present}
module tb_lane_gate_scheduler;

    logic clk_1Hz = 1'b0;
    logic rst = 1'b1;
    logic entry_req = 1'b0;
    logic exit_req = 1'b0;
    logic full = 1'b0;
    logic empty = 1'b0;
    logic car_present = 1'b0;
    logic entry_grant, exit_grant, served_dir, motor_up;
    logic motor_down, gate_open, busy, lane_fault;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [5:0] in;
        logic [7:0] exp;
        string      tag;
    } vec_t;

    vec_t tbl[$];

    lane_gate_scheduler dut (
        .clk_1Hz    (clk_1Hz),
        .rst        (rst),
        .entry_req  (entry_req),
        .exit_req   (exit_req),
        .full       (full),
        .empty      (empty),
        .car_present(car_present),
        .entry_grant(entry_grant),
        .exit_grant (exit_grant),
        .served_dir (served_dir),
        .motor_up   (motor_up),
        .motor_down (motor_down),
        .gate_open  (gate_open),
        .busy       (busy),
        .lane_fault (lane_fault)
    );

    always #5 clk_1Hz = ~clk_1Hz;

    function automatic logic [7:0] outs();
        return {entry_grant, exit_grant, served_dir, motor_up,
                motor_down, gate_open, busy, lane_fault};
    endfunction

    function automatic void add(input logic [5:0] in, input logic [7:0] exp,
                                input int n, input string tag);
        vec_t v;
        v.in  = in;
        v.exp = exp;
        v.tag = tag;
        for (int i = 0; i < n; i++) tbl.push_back(v);
    endfunction

    task automatic drive(input logic [5:0] in);
        {rst, entry_req, exit_req, full, empty, car_present} = in;
    endtask

    task automatic check(input string tag, input logic [7:0] exp);
        n_vec++;
        if (outs() !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b want %b", tag, outs(), exp);
        end
    endtask

    task automatic step(input logic [5:0] in);
        drive(in);
        @(posedge clk_1Hz);
        #1;
    endtask

    initial begin
        // 1: single entry from reset
        add(6'b010000, 8'b1001_0010, 1, "s1_grant");
        add(6'b000000, 8'b0001_0010, 1, "s1_up");
        add(6'b000000, 8'b0000_0110, 5, "s1_open");
        add(6'b000000, 8'b0000_1010, 2, "s1_down");
        add(6'b000000, 8'b0000_0000, 1, "s1_idle");
        // 3: masking - entry masked by full, exit masked by empty
        add(6'b010100, 8'b0000_0000, 20, "s3_full");
        add(6'b011110, 8'b0000_0000, 5, "s3_both");
        add(6'b011010, 8'b1001_0010, 1, "s3_unfull");
        add(6'b001010, 8'b0001_0010, 1, "s3_up");
        add(6'b001010, 8'b0000_0110, 5, "s3_open");
        add(6'b001010, 8'b0000_1010, 2, "s3_down");
        add(6'b001010, 8'b0000_0000, 1, "s3_idle");
        // 2: reset, then tie with both held: entry, exit, entry
        add(6'b100000, 8'b0000_0000, 1, "s2_rst");
        add(6'b011000, 8'b1001_0010, 1, "s2_g1_entry");
        add(6'b011000, 8'b0001_0010, 1, "s2_up1");
        add(6'b011000, 8'b0000_0110, 5, "s2_open1");
        add(6'b011000, 8'b0000_1010, 2, "s2_down1");
        add(6'b011000, 8'b0000_0000, 1, "s2_idle1");
        add(6'b011000, 8'b0111_0010, 1, "s2_g2_exit");
        add(6'b011000, 8'b0011_0010, 1, "s2_up2");
        add(6'b011000, 8'b0010_0110, 5, "s2_open2");
        add(6'b011000, 8'b0010_1010, 2, "s2_down2");
        add(6'b011000, 8'b0010_0000, 1, "s2_idle2");
        add(6'b011000, 8'b1001_0010, 1, "s2_g3_entry");
        add(6'b000000, 8'b0001_0010, 1, "s2_up3");
        add(6'b000000, 8'b0000_0110, 5, "s2_open3");
        add(6'b000000, 8'b0000_1010, 2, "s2_down3");
        add(6'b000000, 8'b0000_0000, 1, "s2_idle3");
        // 4: occupancy hold and fault
        add(6'b010000, 8'b1001_0010, 1, "s4_grant");
        add(6'b000000, 8'b0001_0010, 1, "s4_up");
        add(6'b000000, 8'b0000_0110, 1, "s4_open");
        add(6'b000001, 8'b0000_0110, 9, "s4_hold");
        add(6'b000001, 8'b0000_0111, 3, "s4_fault");
        add(6'b000000, 8'b0000_0110, 4, "s4_clear");
        add(6'b000000, 8'b0000_1010, 1, "s4_close");
        // 5: obstruction in first closing cycle
        add(6'b000001, 8'b0001_0010, 1, "s5_rev");
        add(6'b000000, 8'b0001_0010, 1, "s5_up");
        add(6'b000000, 8'b0000_0110, 5, "s5_open");
        add(6'b000000, 8'b0000_1010, 2, "s5_down");
        add(6'b000000, 8'b0000_0000, 1, "s5_idle");

        // reset state, checked while rst is still held
        #3;
        check("reset_state", 8'b0000_0000);
        @(negedge clk_1Hz);
        drive(6'b000000);
        @(negedge clk_1Hz);

        foreach (tbl[i]) begin
            step(tbl[i].in);
            check(tbl[i].tag, tbl[i].exp);
        end

        // 6: reset mid-operation while lane_fault is set
        step(6'b010000);
        check("s6_grant", 8'b1001_0010);
        step(6'b000000);
        step(6'b000000);
        for (int i = 0; i < 10; i++) step(6'b000001);
        check("s6_fault_up", 8'b0000_0111);
        #2;
        rst = 1'b1;
        #1;
        check("s6_async_rst", 8'b0000_0000);
        @(negedge clk_1Hz);
        check("s6_rst_hold", 8'b0000_0000);
        // last service was entry; only reset makes entry win this tie
        step(6'b011000);
        check("s6_entry_first", 8'b1001_0010);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
